// File: rtl/lmsm_mem_master_pkg.sv
// Shared definitions for the load/store-multiple memory sequencer: FSM encoding,
// mask/index widths and the LM/SM opcodes the decoder uses to raise In_start.
package lmsm_mem_master_pkg;

    localparam int unsigned LMSM_MASK_W = 8;
    localparam int unsigned LMSM_IDX_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } lmsm_state_t;

    localparam logic [3:0] LMSM_OPC_LM = 4'b0110;
    localparam logic [3:0] LMSM_OPC_SM = 4'b0111;

    function automatic logic lmsm_is_multi_op(input logic [3:0] opcode);
        return (opcode == LMSM_OPC_LM) || (opcode == LMSM_OPC_SM);
    endfunction

    function automatic logic lmsm_is_load_op(input logic [3:0] opcode);
        return opcode == LMSM_OPC_LM;
    endfunction

endpackage

// File: rtl/lmsm_mem_master_lowest_set_bit8.sv
// 8-to-3 priority encoder, lowest set index wins; o_valid flags a nonzero input.
module lowest_set_bit8
    import lmsm_mem_master_pkg::*;
(
    input  logic [LMSM_MASK_W-1:0] i_vec,
    output logic [LMSM_IDX_W-1:0]  o_idx,
    output logic                   o_valid
);

    logic w_found;

    always_comb begin
        o_idx   = '0;
        w_found = 1'b0;
        for (int unsigned i = 0; i < LMSM_MASK_W; i++) begin
            if (!w_found && i_vec[i]) begin
                o_idx   = LMSM_IDX_W'(i);
                w_found = 1'b1;
            end
        end
        o_valid = w_found;
    end

endmodule

// File: rtl/lmsm_mem_master.sv
// Load/store-multiple sequencer: one word per cycle between RF and data memory.
// Define LMSM_ADDR_LIMIT_EN to abort (Out_err) on addresses >= MEM_DEPTH.
module lmsm_mem_master
    import lmsm_mem_master_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 64
) (
    input  logic                  In_clock,
    input  logic                  In_reset,
    input  logic                  In_start,
    input  logic                  In_is_load,
    input  logic [15:0]           In_base_addr,
    input  logic [LMSM_MASK_W-1:0] In_reg_mask,
    output logic                  Out_busy,
    output logic                  Out_done,
    output logic                  Out_err,
    output logic                  Out_Mem_Access_en,
    output logic                  Out_Mem_Access_R_Wbar,
    output logic [15:0]           Out_Mem_Access_addr,
    output logic [15:0]           Out_Mem_Write_data,
    input  logic [15:0]           In_Mem_Read_data,
    output logic [LMSM_IDX_W-1:0] Out_RF_rd_addr,
    input  logic [15:0]           In_RF_rd_data,
    output logic                  Out_RF_wr_en,
    output logic [LMSM_IDX_W-1:0] Out_RF_wr_addr,
    output logic [15:0]           Out_RF_wr_data
);

    if (MEM_DEPTH == 0) begin : g_bad_depth
        $error("lmsm_mem_master: MEM_DEPTH must be nonzero");
    end

    lmsm_state_t           r_state;
    logic                  r_is_load;
    logic [15:0]           r_addr;
    logic [LMSM_MASK_W-1:0] r_mask;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;

    // Last driven values, shown on the ports whenever no transfer is active.
    logic                  r_hold_rwbar;
    logic [15:0]           r_hold_addr;
    logic [15:0]           r_hold_wdata;
    logic [LMSM_IDX_W-1:0] r_hold_rd_addr;
    logic [LMSM_IDX_W-1:0] r_hold_wr_addr;
    logic [15:0]           r_hold_wr_data;

    logic [LMSM_IDX_W-1:0]  w_idx;
    logic                   w_valid;
    logic                   w_in_xfer;
    logic                   w_limit;
    logic [LMSM_MASK_W-1:0] w_mask_next;

    lowest_set_bit8 u_lsb (
        .i_vec   (r_mask),
        .o_idx   (w_idx),
        .o_valid (w_valid)
    );

    assign w_in_xfer   = (r_state == ST_XFER);
    assign w_mask_next = r_mask & ~(LMSM_MASK_W'(1) << w_idx);

`ifdef LMSM_ADDR_LIMIT_EN
    assign w_limit = w_in_xfer && (32'(r_addr) >= MEM_DEPTH);
`else
    assign w_limit = 1'b0;
`endif

    always_ff @(posedge In_clock or posedge In_reset) begin
        if (In_reset) begin
            r_state        <= ST_IDLE;
            r_is_load      <= 1'b0;
            r_addr         <= '0;
            r_mask         <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_err          <= 1'b0;
            r_hold_rwbar   <= 1'b1;
            r_hold_addr    <= '0;
            r_hold_wdata   <= '0;
            r_hold_rd_addr <= '0;
            r_hold_wr_addr <= '0;
            r_hold_wr_data <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (In_start) begin
                        r_is_load <= In_is_load;
                        r_addr    <= In_base_addr;
                        r_mask    <= In_reg_mask;
                        r_busy    <= 1'b1;
                        if (In_reg_mask != '0) begin
                            r_state <= ST_XFER;
                        end else begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_XFER: begin
                    r_hold_rwbar <= r_is_load;
                    r_hold_addr  <= r_addr;
                    if (r_is_load) begin
                        r_hold_wr_addr <= w_idx;
                        r_hold_wr_data <= In_Mem_Read_data;
                    end else begin
                        r_hold_rd_addr <= w_idx;
                        r_hold_wdata   <= In_RF_rd_data;
                    end
                    r_mask <= w_mask_next;
                    r_addr <= r_addr + 16'd1;
                    // An out-of-range slot aborts the whole transfer with an error pulse.
                    if (w_limit) begin
                        r_state <= ST_DONE;
                        r_err   <= 1'b1;
                    end else if (w_mask_next == '0) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign Out_busy = r_busy;
    assign Out_done = r_done;
    assign Out_err  = r_err;

    // Data paths are combinational in XFER so read data lands in the RF the same cycle.
    assign Out_Mem_Access_en     = w_in_xfer && w_valid && !w_limit;
    assign Out_Mem_Access_R_Wbar = w_in_xfer ? r_is_load : r_hold_rwbar;
    assign Out_Mem_Access_addr   = w_in_xfer ? r_addr : r_hold_addr;
    assign Out_Mem_Write_data    = (w_in_xfer && !r_is_load) ? In_RF_rd_data : r_hold_wdata;
    assign Out_RF_rd_addr        = (w_in_xfer && !r_is_load) ? w_idx : r_hold_rd_addr;
    assign Out_RF_wr_en          = w_in_xfer && r_is_load && w_valid && !w_limit;
    assign Out_RF_wr_addr        = (w_in_xfer && r_is_load) ? w_idx : r_hold_wr_addr;
    assign Out_RF_wr_data        = (w_in_xfer && r_is_load) ? In_Mem_Read_data : r_hold_wr_data;

endmodule

// File: tb/tb_lmsm_mem_master.sv
// Randomized bench for lmsm_mem_master with a transaction-level memory/RF model.
module tb_lmsm_mem_master;

`ifdef LMSM_ADDR_LIMIT_EN
    localparam bit LIMIT = 1'b1;
`else
    localparam bit LIMIT = 1'b0;
`endif
    localparam int unsigned DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        In_start = 1'b0;
    logic        In_is_load = 1'b0;
    logic [15:0] In_base_addr = '0;
    logic [7:0]  In_reg_mask = '0;
    logic        Out_busy, Out_done, Out_err;
    logic        Out_Mem_Access_en, Out_Mem_Access_R_Wbar;
    logic [15:0] Out_Mem_Access_addr, Out_Mem_Write_data, In_Mem_Read_data;
    logic [2:0]  Out_RF_rd_addr, Out_RF_wr_addr;
    logic [15:0] In_RF_rd_data, Out_RF_wr_data;
    logic        Out_RF_wr_en;

    logic [15:0] mem_dut [0:65535];
    logic [15:0] mem_ref [0:65535];
    logic [15:0] rf_dut  [0:7];
    logic [15:0] rf_ref  [0:7];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lmsm_mem_master #(.MEM_DEPTH(DEPTH)) dut (
        .In_clock              (clk),
        .In_reset              (rst),
        .In_start              (In_start),
        .In_is_load            (In_is_load),
        .In_base_addr          (In_base_addr),
        .In_reg_mask           (In_reg_mask),
        .Out_busy              (Out_busy),
        .Out_done              (Out_done),
        .Out_err               (Out_err),
        .Out_Mem_Access_en     (Out_Mem_Access_en),
        .Out_Mem_Access_R_Wbar (Out_Mem_Access_R_Wbar),
        .Out_Mem_Access_addr   (Out_Mem_Access_addr),
        .Out_Mem_Write_data    (Out_Mem_Write_data),
        .In_Mem_Read_data      (In_Mem_Read_data),
        .Out_RF_rd_addr        (Out_RF_rd_addr),
        .In_RF_rd_data         (In_RF_rd_data),
        .Out_RF_wr_en          (Out_RF_wr_en),
        .Out_RF_wr_addr        (Out_RF_wr_addr),
        .Out_RF_wr_data        (Out_RF_wr_data)
    );

    assign In_Mem_Read_data = mem_dut[Out_Mem_Access_addr];
    assign In_RF_rd_data    = rf_dut[Out_RF_rd_addr];

    always @(posedge clk) begin
        if (Out_Mem_Access_en && !Out_Mem_Access_R_Wbar)
            mem_dut[Out_Mem_Access_addr] <= Out_Mem_Write_data;
        if (Out_RF_wr_en)
            rf_dut[Out_RF_wr_addr] <= Out_RF_wr_data;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},  32'(Out_busy), 0);
        chk({tag, "_done"},  32'(Out_done), 0);
        chk({tag, "_err"},   32'(Out_err), 0);
        chk({tag, "_en"},    32'(Out_Mem_Access_en), 0);
        chk({tag, "_rwbar"}, 32'(Out_Mem_Access_R_Wbar), 1);
        chk({tag, "_addr"},  32'(Out_Mem_Access_addr), 0);
        chk({tag, "_wdata"}, 32'(Out_Mem_Write_data), 0);
        chk({tag, "_rdad"},  32'(Out_RF_rd_addr), 0);
        chk({tag, "_wren"},  32'(Out_RF_wr_en), 0);
        chk({tag, "_wrad"},  32'(Out_RF_wr_addr), 0);
        chk({tag, "_wrdt"},  32'(Out_RF_wr_data), 0);
    endtask

    task automatic chk_rf();
        for (int r = 0; r < 8; r++)
            chk($sformatf("rf_R%0d", r), 32'(rf_dut[r]), 32'(rf_ref[r]));
    endtask

    // One LM/SM operation; abort_at > 0 pulses reset just after that XFER slot's edge.
    task automatic run_op(input bit ld, input logic [15:0] base, input logic [7:0] m,
                          input int unsigned abort_at, input bit noise);
        int unsigned cyc = 0;
        logic [15:0] a = base;
        logic [15:0] last_a = '0;
        bit lim = 1'b0;
        @(negedge clk);
        In_start = 1'b1; In_is_load = ld; In_base_addr = base; In_reg_mask = m;
        @(negedge clk);
        In_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) begin
                cyc++;
                lim = LIMIT && (a >= 16'(DEPTH));
                chk("x_busy",  32'(Out_busy), 1);
                chk("x_done",  32'(Out_done), 0);
                chk("x_en",    32'(Out_Mem_Access_en), 32'(!lim));
                chk("x_addr",  32'(Out_Mem_Access_addr), 32'(a));
                chk("x_rwbar", 32'(Out_Mem_Access_R_Wbar), 32'(ld));
                if (ld) begin
                    chk("x_wren", 32'(Out_RF_wr_en), 32'(!lim));
                    chk("x_wrad", 32'(Out_RF_wr_addr), i);
                    chk("x_wrdt", 32'(Out_RF_wr_data), 32'(mem_ref[a]));
                    if (!lim) rf_ref[i] = mem_ref[a];
                end else begin
                    chk("x_wren",  32'(Out_RF_wr_en), 0);
                    chk("x_rdad",  32'(Out_RF_rd_addr), i);
                    chk("x_wdata", 32'(Out_Mem_Write_data), 32'(rf_ref[i]));
                    if (!lim) mem_ref[a] = rf_ref[i];
                end
                last_a = a;
                a = a + 16'd1;
                if (abort_at == cyc) begin
                    @(posedge clk);
                    #1 rst = 1'b1;
                    #1 chk_reset_outputs("midrst");
                    @(negedge clk);
                    rst = 1'b0;
                    chk_rf();
                    return;
                end
                if (noise) begin
                    In_start = 1'b1; In_is_load = 1'($urandom);
                    In_base_addr = 16'($urandom); In_reg_mask = 8'($urandom);
                end
                @(negedge clk);
                In_start = 1'b0;
                if (lim) break;
            end
        end
        chk("d_busy",  32'(Out_busy), 1);
        chk("d_en",    32'(Out_Mem_Access_en), 0);
        chk("d_wren",  32'(Out_RF_wr_en), 0);
        chk("d_done",  32'(Out_done), 32'(!lim));
        chk("d_err",   32'(Out_err), 32'(lim));
        if (cyc > 0) chk("d_hold_addr", 32'(Out_Mem_Access_addr), 32'(last_a));
        @(negedge clk);
        chk("i_busy", 32'(Out_busy), 0);
        chk("i_done", 32'(Out_done), 0);
        chk("i_err",  32'(Out_err), 0);
        chk_rf();
        if (!ld) begin
            a = base;
            for (int unsigned k = 0; k < cyc; k++) begin
                chk("mem", 32'(mem_dut[a]), 32'(mem_ref[a]));
                a = a + 16'd1;
            end
        end
    endtask

    initial begin
        logic [15:0] v;
        for (int i = 0; i < 65536; i++) begin
            v = 16'($urandom);
            mem_dut[i] = v; mem_ref[i] = v;
        end
        for (int r = 0; r < 8; r++) begin
            v = 16'($urandom);
            rf_dut[r] = v; rf_ref[r] = v;
        end
        #12;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        mem_dut[21] = 16'h000F; mem_ref[21] = 16'h000F;
        mem_dut[22] = 16'h0000; mem_ref[22] = 16'h0000;
        run_op(1'b1, 16'd21, 8'b0000_0101, 0, 1'b0);
        chk("load_R0", 32'(rf_dut[0]), 32'h000F);
        chk("load_R2", 32'(rf_dut[2]), 32'h0000);

        rf_dut[1] = 16'h1234; rf_ref[1] = 16'h1234;
        rf_dut[7] = 16'hBEEF; rf_ref[7] = 16'hBEEF;
        run_op(1'b0, 16'd40, 8'b1000_0010, 0, 1'b0);
        chk("store_m40", 32'(mem_dut[40]), 32'h1234);
        chk("store_m41", 32'(mem_dut[41]), 32'hBEEF);

        run_op(1'b1, 16'd5, 8'h00, 0, 1'b0);
        run_op(1'b0, 16'hFFFF, 8'b0000_0011, 0, 1'b0);
        run_op(1'b1, 16'd30, 8'hFF, 3, 1'b0);
        run_op(1'b1, 16'd10, 8'b0101_0001, 0, 1'b0);
        run_op(1'b1, 16'd62, 8'b0000_1111, 0, 1'b0);

        for (int t = 0; t < 60; t++) begin
            logic [15:0] b;
            b = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 70)) : 16'($urandom);
            run_op(1'($urandom), b, 8'($urandom), 0, 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
